// File: rtl/counter_display_pkg.sv
// Shared types and constants for the counter seven-segment display stage.
package counter_display_pkg;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2
  } digit_e;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;
  localparam int         NUM_DIGITS = 3;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/counter_seg7_display.sv
// Scans counter value and 8-bit carry-out tally onto a multiplexed 7-seg display.
// Optional macro SEG7_ZERO_BLANK_EN blanks digit 2 while the tally high nibble is 0.
module counter_seg7_display
  import counter_display_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] q,
  input  logic       cout,
  input  logic       tally_clr,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [3:0]           q_meta_q, q_sync_q;
  logic                 cout_meta_q, cout_sync_q, cout_prev_q;
  logic                 tclr_meta_q, tclr_sync_q;
  logic [7:0]           tally_q, tally_d;
  logic [SCAN_BITS-1:0] div_q;
  logic [1:0]           state_q, state_d;
  logic [7:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [3:0]           nibble;
  logic [6:0]           seg_dec;
  logic                 cout_rise;
  logic                 scan_tick;

  assign cout_rise = cout_sync_q & ~cout_prev_q;
  assign scan_tick = &div_q;

  // Clear has priority over a coincident carry edge.
  always_comb begin
    tally_d = tally_q;
    if (tclr_sync_q)
      tally_d = 8'h00;
    else if (cout_rise)
      tally_d = tally_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    if (scan_tick) begin
      case (state_q)
        D0:      state_d = D1;
        D1:      state_d = D2;
        default: state_d = D0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      D1:      nibble = tally_q[3:0];
      D2:      nibble = tally_q[7:4];
      default: nibble = q_sync_q;
    endcase
  end

  hex_to_seg7 u_dec (
    .nib_i (nibble),
    .seg_o (seg_dec)
  );

  // Encoding 3 is never a real digit, so it drives nothing for its one slot.
  always_comb begin
    an_d  = AN_ALL_OFF;
    seg_d = seg_dec;
    dp_d  = ~((state_q == D0) & cout_sync_q);
    if (int'(state_q) < NUM_DIGITS)
      an_d[state_q] = 1'b0;
    else
      seg_d = SEG_BLANK;
`ifdef SEG7_ZERO_BLANK_EN
    if ((state_q == D2) && (tally_q[7:4] == 4'h0)) begin
      an_d  = AN_ALL_OFF;
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_meta_q    <= 4'h0;
      q_sync_q    <= 4'h0;
      cout_meta_q <= 1'b0;
      cout_sync_q <= 1'b0;
      cout_prev_q <= 1'b0;
      tclr_meta_q <= 1'b0;
      tclr_sync_q <= 1'b0;
      tally_q     <= 8'h00;
      div_q       <= '0;
      state_q     <= D0;
      an_q        <= AN_ALL_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      q_meta_q    <= q;
      q_sync_q    <= q_meta_q;
      cout_meta_q <= cout;
      cout_sync_q <= cout_meta_q;
      cout_prev_q <= cout_sync_q;
      tclr_meta_q <= tally_clr;
      tclr_sync_q <= tclr_meta_q;
      tally_q     <= tally_d;
      div_q       <= div_q + SCAN_BITS'(1);
      state_q     <= state_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_counter_seg7_display.sv
// Randomized self-checking bench for counter_seg7_display (SCAN_BITS = 2).
module tb_counter_seg7_display;

  localparam int SB   = 2;
  localparam int SLOT = 1 << SB;

  logic       clk;
  logic       clr_n;
  logic [3:0] q;
  logic       cout;
  logic       tally_clr;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;
  int cyc;
  int tallyModel;

  counter_seg7_display #(.SCAN_BITS(SB)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .q         (q),
    .cout      (cout),
    .tally_clr (tally_clr),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since the last reset release; drives the scan-position model.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] hexSeg(input int v);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v % 16];
  endfunction

  function automatic int digitNow();
    return ((cyc - 1) / SLOT) % 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected display for the present scan slot, assuming inputs have been stable.
  task automatic checkOutput(input string tag);
    int         d;
    int         nib;
    logic [7:0] expAn;
    logic [6:0] expSeg;
    logic       expDp;
    d = digitNow();
    nib = (d == 0) ? int'(q) : (d == 1) ? (tallyModel % 16) : (tallyModel / 16);
    expAn  = ~(8'h01 << d);
    expSeg = hexSeg(nib);
    expDp  = !(d == 0 && cout);
`ifdef SEG7_ZERO_BLANK_EN
    if (d == 2 && tallyModel / 16 == 0) begin
      expAn  = 8'hFF;
      expSeg = 7'h7F;
    end
`endif
    checkVal({tag, "_an"}, an, expAn);
    checkVal({tag, "_seg"}, {1'b0, seg}, {1'b0, expSeg});
    checkVal({tag, "_dp"}, {7'b0, dp}, {7'b0, expDp});
    checkVal({tag, "_an_hi"}, {3'b0, an[7:3]}, 8'h1F);
  endtask

  task automatic checkScan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag);
    end
  endtask

  // Randomly shaped carry pulses; the tally model counts them unless clear is held.
  task automatic applyStimulus(input int nPulses);
    for (int i = 0; i < nPulses; i++) begin
      cout = 1'b1;
      repeat ($urandom_range(2, 5)) tick();
      if (!tally_clr) tallyModel = (tallyModel + 1) % 256;
      cout = 1'b0;
      repeat ($urandom_range(4, 6)) tick();
    end
  endtask

  initial begin
    clr_n = 1'b0;
    q = 4'hA;
    cout = 1'b0;
    tally_clr = 1'b0;
    tallyModel = 0;

    // Reset values
    repeat (3) tick();
    checkVal("rst_an", an, 8'hFF);
    checkVal("rst_seg", {1'b0, seg}, 8'h7F);
    checkVal("rst_dp", {7'b0, dp}, 8'h01);
    clr_n = 1'b1;
    tick();
    checkVal("first_an", an, 8'hFE);
    tick();
    tick();
    checkVal("first_seg", {1'b0, seg}, 8'b00001000);

    // Scan order over several full rotations
    checkScan("scan", 12);

    // Random digit values and tally increments
    for (int r = 0; r < 6; r++) begin
      q = 4'($urandom);
      applyStimulus($urandom_range(0, 5));
      repeat (4) tick();
      checkScan("rand", 12);
    end

    // Wrap: 256 more pulses return the tally to the same value
    applyStimulus(256);
    repeat (4) tick();
    checkScan("wrap", 12);

    // Clear wins over a coincident carry edge and holds the tally at 0
    tick();
    tally_clr = 1'b1;
    cout = 1'b1;
    tallyModel = 0;
    repeat (4) tick();
    checkScan("clr", 12);
    cout = 1'b0;
    repeat (3) tick();
    applyStimulus(3);
    repeat (4) tick();
    checkScan("clr_hold", 12);
    tally_clr = 1'b0;
    repeat (4) tick();

    // Mid-operation reset while showing digit 1 with tally 0x5C
    applyStimulus(92);
    repeat (4) tick();
    checkScan("pre_rst", 12);
    for (int i = 0; i < 3 * SLOT && digitNow() != 1; i++) tick();
    #2;
    clr_n = 1'b0;
    #1;
    checkVal("mid_rst_an", an, 8'hFF);
    checkVal("mid_rst_seg", {1'b0, seg}, 8'h7F);
    checkVal("mid_rst_dp", {7'b0, dp}, 8'h01);
    tallyModel = 0;
    tick();
    tick();
    clr_n = 1'b1;
    tick();
    checkVal("restart_an", an, 8'hFE);
    repeat (3) tick();
    checkScan("post_rst", 12);

    // High-nibble-zero tally on digit 2
    applyStimulus(7);
    repeat (4) tick();
    checkScan("blank", 12);
    for (int i = 0; i < 3 * SLOT && digitNow() != 2; i++) tick();
`ifdef SEG7_ZERO_BLANK_EN
    checkVal("d2_an", an, 8'hFF);
    checkVal("d2_seg", {1'b0, seg}, 8'h7F);
`else
    checkVal("d2_an", an, 8'hFB);
    checkVal("d2_seg", {1'b0, seg}, 8'b01000000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_seg7_display.md
# counter_seg7_display

Downstream display stage for the 4-bit load/clear counter. It takes the counter's value and carry output and drives the board's 8-digit, active-low, multiplexed seven-segment display from the 100 MHz system clock. It counts carry-out rising edges into an 8-bit overflow tally and scans three digits:
- digit 0: the counter value, in hex;
- digits 1–2: the overflow tally, low and high nibble, in hex.

## Interface
Parameters:
- SCAN_BITS, 17, log2 of clk cycles per digit slot (17 gives about 763 Hz per slot at 100 MHz).

Ports:
- clk  input  1  system clock (100 MHz); one clock domain.
- clr_n  input  1  asynchronous active-low reset.
- q  input  4  counter value; asynchronous to clk.
- cout  input  1  counter carry-out, level; asynchronous to clk.
- tally_clr  input  1  clears the overflow tally; level from a switch; asynchronous to clk.
- an  output  8  digit anodes, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- Synchronisation:
  - q, cout and tally_clr each pass through a 2-flop synchroniser into clk.
  - q is displayed from its synchronised copy.
- Edge detect: a rising edge is a registered previous sample of 0 and a current synchronised sample of 1.
- Overflow tally (8 bits):
  - Increments by 1 on each detected cout rising edge.
  - Wraps from 0xFF to 0x00.
  - Held at 0 while synchronised tally_clr = 1.
  - If tally_clr and an edge occur in the same cycle, clear wins.
- Scan divider: a free-running SCAN_BITS-bit counter. Its terminal count (all ones) asserts scan_tick for 1 cycle.
- Digit index FSM, states D0 → D1 → D2 → D0:
  - Advances only on scan_tick; holds otherwise.
  - No other states. Unused encoding 3 returns to D0 on the next tick.
- Output register, updated every cycle from the current state:
  - an: one-hot low on bit = digit index; an[7:3] always 1.
  - seg: hex decode of the digit's nibble (D0: q_sync, D1: tally[3:0], D2: tally[7:4]). Codes 0–F use standard patterns, e.g. 0 → 7'b1000000, F → 7'b0001110.
  - dp: 0 only in D0 while synchronised cout = 1; otherwise 1.
- Reset mid-operation: asserting clr_n low immediately forces every register to its reset value, tally included. Operation restarts from D0.

## Timing
- Reset values:
  - an = 8'hFF (all digits off), seg = 7'h7F, dp = 1.
  - Digit index D0, divider 0, tally 0x00, all synchroniser and edge flops 0.
- Tally latency:
  - Asynchronous cout rise to edge-detect pulse: 2–3 clk.
  - Tally register updates on the following edge.
  - Visible on seg one cycle later, if that digit is the one being scanned.
- q latency: change on q reaches seg 3 clk later when in D0.
- Scan timing:
  - Each digit is active for exactly 2^SCAN_BITS cycles.
  - an and seg change together, one cycle after scan_tick, with no ghosting cycle between digits.
- tally_clr effect: the tally reads 0 on the 3rd clk after tally_clr rises.

## Configuration
- SEG7_ZERO_BLANK_EN:
  - Defined: when tally[7:4] == 0, digit 2 is blanked (an[2] = 1 during D2, seg = 7'h7F). The scan timing of D2 is unchanged.
  - Undefined: digit 2 always shows the high nibble, including 0.

## Structure
- Package counter_display_pkg:
  - Digit-index typedef (D0, D1, D2).
  - Constants SEG_BLANK = 7'h7F and AN_ALL_OFF = 8'hFF.
  - Constant NUM_DIGITS = 3.
- Sub-module hex_to_seg7: purely combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed nibble.
- Everything else is in one module.

## Test plan
(All scenarios use SCAN_BITS = 2.)
1. Reset: hold clr_n = 0 with q = 4'hA → an = 8'hFF, seg = 7'h7F, dp = 1. After release, first D0 slot shows seg = 7'b0001000 ("A") with an = 8'b11111110.
2. Scan order: run 12 cycles → an cycles FE, FD, FB, FE, each for exactly 4 cycles; an[7:3] never 0.
3. Tally count and wrap: apply 3 cout pulses (low ≥4 cycles between them) → tally = 0x03. Apply 256 more → tally = 0x03, confirming the 0xFF → 0x00 wrap.
4. Clear priority: tally_clr rises together with a cout rise → tally = 0x00 and stays 0 while tally_clr is held.
5. Mid-operation reset: assert clr_n in state D1 with tally = 0x5C → all outputs return to reset values in the same cycle. After release, tally = 0x00 and scanning starts at D0.
6. SEG7_ZERO_BLANK_EN:
   - Defined, tally = 0x07: during D2, an = 8'hFF.
   - Undefined: an = 8'hFB and seg = 7'b1000000.
